// File: rtl/commutator_pkg.sv
// Shared definitions for the commutating mux/demux pair: slot count, demux states and the
// bit-reversed slot select encoding used on the control lines.
package commutator_pkg;

  localparam int unsigned SLOTS = 8;

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    FULL
  } demux_state_t;

  // Select code driven on control for slot k; the mux side decodes the same encoding.
  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/commutator_slot_counter.sv
// 3-bit slot counter for the decommutator; also registers the bit-reversed control code so
// that control changes on the same edge as the slot.
module commutator_slot_counter
  import commutator_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       set_one_i,
  input  logic       clear_i,
  output logic [2:0] slot_o,
  output logic [2:0] control_o
);

  logic [2:0] slot_q, slot_d;
  logic [2:0] control_q;

  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = 3'd0;
    end else if (set_one_i) begin
      slot_d = 3'd1;
    end else if (inc_i) begin
      slot_d = slot_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q    <= 3'd0;
      control_q <= 3'd0;
    end else begin
      slot_q    <= slot_d;
      control_q <= bitrev3(slot_d);
    end
  end

  assign slot_o    = slot_q;
  assign control_o = control_q;

endmodule

// File: rtl/commutator_demux_1_to_8.sv
// Sequential 1-to-8 decommutator: gathers serial samples into an 8-lane frame, optionally
// aligned to in_sync, and hands complete frames downstream over a ready/valid interface.
module commutator_demux_1_to_8
  import commutator_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter bit          SYNC_ENABLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sync,
  output logic                   in_ready,
  output logic [2:0]             control,
  output logic                   out_valid,
  output logic [SLOTS*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic                   sync_err
);

  localparam int unsigned FrameW = SLOTS * WIDTH;

  demux_state_t      state_q, state_d;
  logic [FrameW-1:0] asm_q, asm_d;
  logic [FrameW-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              slot_inc, slot_set_one, slot_clear;
  logic [2:0]        slot;
  logic              accept;
  logic              resync;

  commutator_slot_counter u_slot_counter (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (slot_inc),
    .set_one_i (slot_set_one),
    .clear_i   (slot_clear),
    .slot_o    (slot),
    .control_o (control)
  );

  assign in_ready = (state_q != FULL);
  assign accept   = in_valid && in_ready;
  assign resync   = SYNC_ENABLE && in_sync && (slot != 3'd0);

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready;
    sync_err_d   = 1'b0;
    slot_inc     = 1'b0;
    slot_set_one = 1'b0;
    slot_clear   = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (accept && in_sync) begin
          asm_d[0 +: WIDTH] = in_data;
          slot_set_one      = 1'b1;
          state_d           = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (resync) begin
            // Sync arrived early: drop the partial frame and restart it with this sample.
            asm_d             = '0;
            asm_d[0 +: WIDTH] = in_data;
            slot_set_one      = 1'b1;
            sync_err_d        = 1'b1;
          end else begin
            asm_d[slot*WIDTH +: WIDTH] = in_data;
            slot_inc                   = 1'b1;
            if (slot == 3'(SLOTS - 1)) begin
              if (!out_valid_q || out_ready) begin
                out_data_d  = asm_d;
                out_valid_d = 1'b1;
              end else begin
                state_d = FULL;
              end
            end
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          out_data_d  = asm_q;
          out_valid_d = 1'b1;
          slot_clear  = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (SYNC_ENABLE) begin
        state_q <= HUNT;
      end else begin
        state_q <= COLLECT;
      end
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule
